// File: rtl/pipe_ctrl_pkg.sv
// Shared FSM state type, MIPS opcode constants and default register-specifier width
// for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BR_FLUSH = 2'd2,
    ERR      = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The stall_cnt/flush_cnt statistics
// outputs exist only when HAZARD_STATS_EN is defined.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = pipe_ctrl_pkg::REG_W,
  parameter int CNT_W = 16
);
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             mem_branch;
  logic             mem_zero;
  logic             mem_access;
  logic             dmem_ready;

  logic dmem_req;
  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_flush;
  logic exmem_flush;
  logic idex_bubble;
  logic pc_src;
  logic err;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`else
  // CNT_W only sizes the statistics counters.
  if (CNT_W > 0) begin : g_no_stats
  end
`endif

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
    output mem_branch, mem_zero, mem_access, dmem_ready,
    input  dmem_req, pc_write, ifid_write, ifid_flush, idex_flush,
    input  exmem_flush, idex_bubble, pc_src, err
`ifdef HAZARD_STATS_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
    input  mem_branch, mem_zero, mem_access, dmem_ready,
    output dmem_req, pc_write, ifid_write, ifid_flush, idex_flush,
    output exmem_flush, idex_bubble, pc_src, err
`ifdef HAZARD_STATS_EN
    , output stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard term: the LW in EX writes a register the ID instruction reads.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = pipe_ctrl_pkg::REG_W
) (
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rt_i,
  output logic             load_use_o
);

  // Register 0 is hardwired zero, so a load into it never creates a dependency.
  assign load_use_o = ex_mem_read_i && (ex_rt_i != '0) &&
                      ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: memory stall, branch flush and load-use bubble.
// Optional stall/flush statistics counters are built when HAZARD_STATS_EN is defined.
module pipe_hazard_ctrl #(
  parameter int REG_W   = pipe_ctrl_pkg::REG_W,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);
  import pipe_ctrl_pkg::*;

  localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(TIMEOUT);

  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [TO_W-1:0] wait_inc;
  logic            load_use;
  logic            mem_stall;
  logic            br_taken;

  logic pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
  logic idex_bubble, pc_src, dmem_req, err;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_rs_i       (bus.id_rs),
    .id_rt_i       (bus.id_rt),
    .id_uses_rt_i  (bus.id_uses_rt),
    .ex_mem_read_i (bus.ex_mem_read),
    .ex_rt_i       (bus.ex_rt),
    .load_use_o    (load_use)
  );

  assign mem_stall = bus.mem_access && !bus.dmem_ready;
  assign br_taken  = bus.mem_branch && bus.mem_zero;
  assign wait_inc  = wait_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    idex_bubble = 1'b0;
    pc_src      = 1'b0;
    dmem_req    = 1'b0;
    err         = 1'b0;

    case (state_q)
      RUN, BR_FLUSH: begin
        dmem_req = bus.mem_access;
        state_d  = RUN;
        if (mem_stall) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          wait_cnt_d = '0;
          state_d    = MEM_WAIT;
        end else if (br_taken) begin
          pc_src      = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          state_d     = BR_FLUSH;
        end else if (load_use && (state_q == RUN)) begin
          // In BR_FLUSH the ID slot holds a flushed NOP, so its match is spurious.
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end

      MEM_WAIT: begin
        dmem_req = bus.mem_access;
        if (bus.dmem_ready) begin
          // Resume: the frozen branch/load-use situation is resolved this cycle.
          state_d = RUN;
          if (br_taken) begin
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = BR_FLUSH;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end else begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          wait_cnt_d = wait_inc;
          if (wait_inc == TIMEOUT_V) begin
            state_d = ERR;
          end
        end
      end

      ERR: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        err        = 1'b1;
      end

      default: state_d = RUN;
    endcase

    // Reset forces the outputs immediately, without waiting for a clock edge.
    if (!rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      idex_bubble = 1'b0;
      pc_src      = 1'b0;
      dmem_req    = 1'b0;
      err         = 1'b0;
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.pc_src      = pc_src;
  assign bus.dmem_req    = dmem_req;
  assign bus.err         = err;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_evt, flush_evt;

  // Every frozen-PC cycle outside ERR is either a load-use or a memory stall.
  assign stall_evt = rst && !pc_write && (state_q != ERR);
  assign flush_evt = pc_src;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  // CNT_W only sizes the statistics counters.
  if (CNT_W > 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: a default DUT plus a TIMEOUT=3 DUT
// share clock, reset and stimulus; expectations are queued and checked at negedge.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int RW = 5;

  // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, idex_bubble, pc_src, dmem_req, err}
  localparam logic [8:0] RSTV = 9'b000000000;
  localparam logic [8:0] DEF  = 9'b110000000;
  localparam logic [8:0] LU   = 9'b000001000;
  localparam logic [8:0] BR   = 9'b111110100;
  localparam logic [8:0] BRM  = 9'b111110110;
  localparam logic [8:0] MST  = 9'b000000010;
  localparam logic [8:0] MRDY = 9'b110000010;
  localparam logic [8:0] ERRV = 9'b000000001;

  typedef struct {
    logic [8:0] exp;
    bit         sel;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_W(RW)) bus0 ();
  pipe_hazard_ctrl_if #(.REG_W(RW)) bus1 ();

  pipe_hazard_ctrl #(.REG_W(RW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  pipe_hazard_ctrl #(.REG_W(RW), .TIMEOUT(3), .TO_W(8)) u_dut_to (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [8:0] outs(input bit sel);
    if (sel)
      return {bus1.pc_write, bus1.ifid_write, bus1.ifid_flush, bus1.idex_flush, bus1.exmem_flush,
              bus1.idex_bubble, bus1.pc_src, bus1.dmem_req, bus1.err};
    return {bus0.pc_write, bus0.ifid_write, bus0.ifid_flush, bus0.idex_flush, bus0.exmem_flush,
            bus0.idex_bubble, bus0.pc_src, bus0.dmem_req, bus0.err};
  endfunction

  task automatic set_in(input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic urt,
                        input logic exmr, input logic [RW-1:0] ert, input logic br,
                        input logic zr, input logic acc, input logic rdy);
    bus0.id_rs = rs;  bus0.id_rt = rt;  bus0.id_uses_rt = urt;
    bus0.ex_mem_read = exmr;  bus0.ex_rt = ert;
    bus0.mem_branch = br;  bus0.mem_zero = zr;  bus0.mem_access = acc;  bus0.dmem_ready = rdy;
    bus1.id_rs = rs;  bus1.id_rt = rt;  bus1.id_uses_rt = urt;
    bus1.ex_mem_read = exmr;  bus1.ex_rt = ert;
    bus1.mem_branch = br;  bus1.mem_zero = zr;  bus1.mem_access = acc;  bus1.dmem_ready = rdy;
  endtask

  task automatic clr();
    set_in('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Queue the expectation for the current cycle, then advance to just after the next edge.
  task automatic step(input bit sel, input logic [8:0] exp, input string name);
    exp_t e;
    e.exp  = exp;
    e.sel  = sel;
    e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are Mealy, so compare mid-cycle once inputs have settled.
  initial begin : monitor
    exp_t       e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = outs(e.sel);
        n_tests++;
        if (act !== e.exp) begin
          n_fail++;
          $display("[TB] FAIL %s dut%0d: got %b want %b", e.name, e.sel, act, e.exp);
        end else begin
          $display("[TB] ok   %s dut%0d: outs=%b", e.name, e.sel, act);
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b0;
    clr();
    @(posedge clk);
    #1;
    step(0, RSTV, "reset_dut0");
    step(1, RSTV, "reset_dut1");
    rst = 1'b1;

    clr();                                    step(0, DEF, "idle_run");
    set_in(8, 0, 0, 1, 8, 0, 0, 0, 0);         step(0, LU,  "load_use_rs");
    clr();                                    step(0, DEF, "after_load_use");
    set_in(0, 9, 1, 1, 9, 0, 0, 0, 0);         step(0, LU,  "load_use_rt");
    set_in(0, 9, 0, 1, 9, 0, 0, 0, 0);         step(0, DEF, "rt_not_used");
    set_in(0, 0, 0, 1, 0, 0, 0, 0, 0);         step(0, DEF, "ex_rt_zero");
    set_in(8, 0, 0, 0, 8, 0, 0, 0, 0);         step(0, DEF, "no_mem_read");

    set_in(0, 0, 0, 0, 0, 1, 1, 0, 0);         step(0, BR,  "branch_taken");
    set_in(5, 0, 0, 1, 5, 0, 0, 0, 0);         step(0, DEF, "br_flush_masks_lu");
                                              step(0, LU,  "lu_after_flush");
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);         step(0, DEF, "branch_not_taken");
    set_in(0, 0, 0, 0, 0, 1, 1, 0, 0);         step(0, BR,  "branch_a");
                                              step(0, BR,  "branch_in_flush");
    clr();                                    step(0, DEF, "flush_exit");
                                              step(0, DEF, "run_again");

    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, MST, $sformatf("mem_wait_%0d", i));
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);         step(0, MRDY, "mem_ready");
    clr();                                    step(0, DEF, "after_mem");

    set_in(0, 0, 0, 0, 0, 1, 1, 1, 0);         step(0, MST, "stall_over_branch");
                                              step(0, MST, "wait_with_branch");
    set_in(0, 0, 0, 0, 0, 1, 1, 1, 1);         step(0, BRM, "branch_on_ready");
    clr();                                    step(0, DEF, "flush_after_ready");

    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);         step(0, MST, "pre_reset_stall");
                                              step(0, MST, "pre_reset_wait");
    rst = 1'b0;                               step(0, RSTV, "async_reset_mid_wait");
                                              step(0, RSTV, "reset_held");
    rst = 1'b1;
    clr();                                    step(0, DEF, "run_after_reset");

    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);         step(1, MST, "to_stall");
                                              step(1, MST, "to_wait1");
                                              step(1, MST, "to_wait2");
                                              step(1, MST, "to_wait3");
                                              step(1, ERRV, "to_err");
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);         step(1, ERRV, "err_sticky_ready");
    clr();                                    step(1, ERRV, "err_sticky_idle");
    rst = 1'b0;                               step(1, RSTV, "err_reset");
    rst = 1'b1;                               step(1, DEF, "run_after_err_reset");

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d pending, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: REG_W, 5, register-specifier width.
REQ-002 Parameter: TIMEOUT, 255, max MEM_WAIT cycles before error; legal 1..2^TO_W-1.
REQ-003 Parameter: TO_W, 8, wait-counter width.
REQ-004 Parameter: CNT_W, 16, statistics-counter width; used only under HAZARD_STATS_EN.
REQ-005 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Port: rst  input  1  reset, asynchronous, active-low.
REQ-007 Ports: id_rs, id_rt  input  REG_W  source specifiers of the instruction in ID.
REQ-008 Port: id_uses_rt  input  1  ID instruction reads rt (R-type, SW, BEQ).
REQ-009 Ports: ex_mem_read  input  1, ex_rt  input  REG_W  EX instruction is LW, and its destination.
REQ-010 Ports: mem_branch, mem_zero  input  1 each  MEM-stage BEQ and ALU zero flag.
REQ-011 Ports: mem_access  input  1, dmem_ready  input  1  MEM-stage LW/SW, data-memory ready.
REQ-012 Port: dmem_req  output  1  data-memory request.
REQ-013 Ports: pc_write, ifid_write  output  1 each  PC and IF/ID load enables.
REQ-014 Ports: ifid_flush, idex_flush, exmem_flush  output  1 each  zero the stage register.
REQ-015 Ports: idex_bubble  output  1  load zero control (wb/mem/ex) into ID/EX; pc_src  output  1  select branch target.
REQ-016 Port: err  output  1  sticky memory-timeout error.

Function
REQ-017 FSM states: RUN, MEM_WAIT, BR_FLUSH, ERR; outputs are Mealy (state plus current inputs), zero added latency.
REQ-018 Defaults every cycle: pc_write=1, ifid_write=1, all flush/bubble/pc_src/dmem_req=0.
REQ-019 Load-use hazard = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
REQ-020 dmem_req SHALL equal mem_access in RUN, BR_FLUSH and MEM_WAIT; 0 in ERR.
REQ-021 Priority in RUN/BR_FLUSH: memory stall > branch taken > load-use.
REQ-022 Memory stall (mem_access & !dmem_ready): pc_write=0, ifid_write=0, idex_bubble=0, next state MEM_WAIT, wait counter cleared.
REQ-023 MEM_WAIT: all enables 0 while !dmem_ready, counter increments; on dmem_ready, enables restored that cycle, next RUN; counter reaching TIMEOUT without ready -> ERR.
REQ-024 Branch taken (mem_branch & mem_zero): pc_src=1, ifid_flush=idex_flush=exmem_flush=1, next BR_FLUSH.
REQ-025 BR_FLUSH lasts exactly one cycle; load-use detection masked (ID holds a flushed NOP); a further taken branch re-enters BR_FLUSH.
REQ-026 Load-use in RUN: pc_write=0, ifid_write=0, idex_bubble=1 for one cycle; state stays RUN.
REQ-027 ERR: pc_write=ifid_write=0, err=1, no exit except reset.
REQ-028 Simultaneous branch and memory stall: stall wins, branch re-evaluated on the cycle dmem_ready arrives.

Reset
REQ-029 While rst=0: state RUN, wait counter 0, err 0, stats counters 0; pc_write=ifid_write=0, dmem_req=0, all flush/bubble/pc_src=0.
REQ-030 Reset asserted mid-MEM_WAIT or in ERR SHALL abandon the operation; first post-reset edge operates from RUN.

Configuration
REQ-031 Macro HAZARD_STATS_EN: when defined, outputs stall_cnt and flush_cnt (CNT_W each) count load-use/memory stall cycles and taken-branch flushes, saturating at all-ones; when undefined, ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-032 Shared package pipe_ctrl_pkg holds the FSM state enum, opcode constants (RTYPE 000000, LW 100011, SW 101011, BEQ 000100) and REG_W.
REQ-033 Combinational sub-module hazard_detect computes the REQ-019 term; FSM and counters live in pipe_hazard_ctrl.

Verification
REQ-034 ex_mem_read=1, ex_rt=8, id_rs=8 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle defaults.
REQ-035 ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall.
REQ-036 mem_branch=1, mem_zero=1 -> pc_src=1, three flushes for one cycle, then BR_FLUSH masks load-use with ex_rt=id_rs=5.
REQ-037 mem_access=1, dmem_ready low 4 cycles -> enables 0 for 4 cycles, restored on 5th with ready.
REQ-038 TIMEOUT=3, dmem_ready never high -> err=1 after 3 wait cycles, stays until rst=0.
REQ-039 rst=0 during MEM_WAIT -> outputs forced to REQ-029 values asynchronously; RUN after release.
